// File: rtl/operator_unit.sv
// Multi-cycle arithmetic unit: single-cycle ADD/SUB/CMP, shift-add MUL on
// pre-offset operands (a+C0)*(b+C1).
module operator_unit #(
  parameter int                 WIDTH = 32,
  parameter logic [WIDTH-1:0]   C0    = WIDTH'(2),
  parameter logic [WIDTH-1:0]   C1    = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  // state  | meaning
  // IDLE   | waiting for start; operands latched on acceptance
  // EXEC   | one-cycle ADD/SUB/CMP, completes next edge
  // PREP   | form x=a+C0, y=b+C1, clear accumulator and bit counter
  // MUL    | one shift-add iteration per cycle, WIDTH iterations
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_PREP, S_MUL} state_t;

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_a, r_b, w_a_nxt, w_b_nxt;
  logic [1:0]         r_op, w_op_nxt;
  logic [WIDTH-1:0]   r_x, r_y, w_x_nxt, w_y_nxt;
  logic               r_carry, w_carry_nxt;
  logic [2*WIDTH-1:0] r_acc, w_acc_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]   r_result, w_result_nxt;
  logic               r_overflow, w_overflow_nxt;
  logic               r_done, w_done_nxt;

  logic [WIDTH:0]     w_sum, w_diff, w_xa, w_yb;
  logic [2*WIDTH-1:0] w_partial, w_acc_add;

  assign w_sum     = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff    = {1'b0, r_a} - {1'b0, r_b};
  assign w_xa      = {1'b0, r_a} + {1'b0, C0};
  assign w_yb      = {1'b0, r_b} + {1'b0, C1};
  assign w_partial = {{WIDTH{1'b0}}, r_x} << r_cnt;
  assign w_acc_add = r_acc + (r_y[r_cnt] ? w_partial : '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_carry    <= 1'b0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_result   <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_a        <= w_a_nxt;
      r_b        <= w_b_nxt;
      r_op       <= w_op_nxt;
      r_x        <= w_x_nxt;
      r_y        <= w_y_nxt;
      r_carry    <= w_carry_nxt;
      r_acc      <= w_acc_nxt;
      r_cnt      <= w_cnt_nxt;
      r_result   <= w_result_nxt;
      r_overflow <= w_overflow_nxt;
      r_done     <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_a_nxt        = r_a;
    w_b_nxt        = r_b;
    w_op_nxt       = r_op;
    w_x_nxt        = r_x;
    w_y_nxt        = r_y;
    w_carry_nxt    = r_carry;
    w_acc_nxt      = r_acc;
    w_cnt_nxt      = r_cnt;
    w_result_nxt   = r_result;
    w_overflow_nxt = r_overflow;
    w_done_nxt     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_a_nxt     = a;
          w_b_nxt     = b;
          w_op_nxt    = op;
          w_state_nxt = (op == OP_MUL) ? S_PREP : S_EXEC;
        end
      end
      S_EXEC: begin
        case (r_op)
          OP_ADD: begin
            w_result_nxt   = w_sum[WIDTH-1:0];
            w_overflow_nxt = w_sum[WIDTH];
          end
          OP_SUB: begin
            w_result_nxt   = w_diff[WIDTH-1:0];
            w_overflow_nxt = (r_a < r_b);
          end
          default: begin
            w_result_nxt   = (r_a == r_b) ? WIDTH'(1) : '0;
            w_overflow_nxt = 1'b0;
          end
        endcase
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_PREP: begin
        w_x_nxt     = w_xa[WIDTH-1:0];
        w_y_nxt     = w_yb[WIDTH-1:0];
        w_carry_nxt = w_xa[WIDTH] | w_yb[WIDTH];
        w_acc_nxt   = '0;
        w_cnt_nxt   = '0;
        w_state_nxt = S_MUL;
      end
      S_MUL: begin
        w_acc_nxt = w_acc_add;
        w_cnt_nxt = r_cnt + CNT_W'(1);
        // final iteration reads the sum directly so result lands with done
        if (r_cnt == CNT_W'(WIDTH-1)) begin
          w_result_nxt   = w_acc_add[WIDTH-1:0];
          w_overflow_nxt = (|w_acc_add[2*WIDTH-1:WIDTH]) | r_carry;
          w_done_nxt     = 1'b1;
          w_state_nxt    = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign result   = r_result;
  assign overflow = r_overflow;

endmodule
